// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller: FSM states and next-PC source encodings.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        TRAP     = 2'd2,
        MRET     = 2'd3
    } state_t;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_BR    = 2'd1;
    localparam logic [1:0] PC_MTVEC = 2'd2;
    localparam logic [1:0] PC_MEPC  = 2'd3;

endpackage

// File: rtl/hazard_unit.sv
// Combinational load-use detector: a load in MW whose destination feeds a source
// operand of the instruction in DE.
module hazard_unit (
    input  logic       valid_de,
    input  logic       valid_mw,
    input  logic       load_mw,
    input  logic [4:0] rd_mw,
    input  logic [4:0] rs1_de,
    input  logic [4:0] rs2_de,
    input  logic       rs1_used_de,
    input  logic       rs2_used_de,
    output logic       load_use
);

    logic [4:0] rs_de   [2];
    logic [1:0] rs_used;
    logic [1:0] rs_hit;

    assign rs_de[0]   = rs1_de;
    assign rs_de[1]   = rs2_de;
    assign rs_used    = {rs2_used_de, rs1_used_de};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign rs_hit[gi] = rs_used[gi] && (rs_de[gi] == rd_mw);
        end
    endgenerate

    // x0 is hard-wired zero, so a load into it never creates a dependency.
    assign load_use = valid_de && valid_mw && load_mw && (rd_mw != 5'd0) && (|rs_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control FSM: load-use stalls, timer-interrupt traps, mret and taken-branch
// redirection for a two-stage (DE/MW) pipeline.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       timer_int,
    input  logic       mstatus_mie,
    input  logic       mie_mtie,
    input  logic       valid_de,
    input  logic       valid_mw,
    input  logic       br_taken_de,
    input  logic       mret_de,
    input  logic [4:0] rs1_de,
    input  logic [4:0] rs2_de,
    input  logic       rs1_used_de,
    input  logic       rs2_used_de,
    input  logic       load_mw,
    input  logic [4:0] rd_mw,
    output logic       stall_f,
    output logic       stall_de,
    output logic       flush_f,
    output logic       flush_de,
    output logic [1:0] pc_sel,
    output logic       trap_take,
    output logic       mret_take
);

    state_t state_reg;
    state_t state_next;
    logic   load_use;
    logic   irq_pend;

    hazard_unit u_hazard (
        .valid_de    (valid_de),
        .valid_mw    (valid_mw),
        .load_mw     (load_mw),
        .rd_mw       (rd_mw),
        .rs1_de      (rs1_de),
        .rs2_de      (rs2_de),
        .rs1_used_de (rs1_used_de),
        .rs2_used_de (rs2_used_de),
        .load_use    (load_use)
    );

    assign irq_pend = timer_int && mie_mtie && mstatus_mie;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        stall_f    = 1'b0;
        stall_de   = 1'b0;
        flush_f    = 1'b0;
        flush_de   = 1'b0;
        pc_sel     = PC_PLUS4;
        trap_take  = 1'b0;
        mret_take  = 1'b0;

        unique case (state_reg)
            RUN: begin
                if (load_use) begin
                    stall_f    = 1'b1;
                    stall_de   = 1'b1;
                    flush_de   = 1'b1;
                    state_next = LD_STALL;
                end else if (irq_pend && valid_de) begin
                    trap_take  = 1'b1;
                    flush_f    = 1'b1;
                    flush_de   = 1'b1;
                    pc_sel     = PC_MTVEC;
                    state_next = TRAP;
                end else if (mret_de && valid_de) begin
                    mret_take  = 1'b1;
                    flush_f    = 1'b1;
                    pc_sel     = PC_MEPC;
                    state_next = MRET;
                end else if (br_taken_de && valid_de) begin
                    flush_f = 1'b1;
                    pc_sel  = PC_BR;
                end
            end
            LD_STALL: begin
                // The held DE instruction now executes with forwarded data; a dependent
                // branch resolves here. mret has no source operands so it never stalls.
                state_next = RUN;
                if (br_taken_de && valid_de) begin
                    flush_f = 1'b1;
                    pc_sel  = PC_BR;
                end
            end
            TRAP: state_next = RUN;
            MRET: state_next = RUN;
            default: state_next = RUN;
        endcase

        // Reset forces every output low immediately so no half-finished pulse escapes.
        if (rst) begin
            state_next = RUN;
            stall_f    = 1'b0;
            stall_de   = 1'b0;
            flush_f    = 1'b0;
            flush_de   = 1'b0;
            pc_sel     = PC_PLUS4;
            trap_take  = 1'b0;
            mret_take  = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: outputs packed as
// {stall_f, stall_de, flush_f, flush_de, pc_sel[1:0], trap_take, mret_take}.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       timer_int, mstatus_mie, mie_mtie;
    logic       valid_de, valid_mw, br_taken_de, mret_de;
    logic [4:0] rs1_de, rs2_de, rd_mw;
    logic       rs1_used_de, rs2_used_de, load_mw;
    logic       stall_f, stall_de, flush_f, flush_de, trap_take, mret_take;
    logic [1:0] pc_sel;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [7:0] O_IDLE = 8'h00;
    localparam logic [7:0] O_HAZ  = 8'hD0;
    localparam logic [7:0] O_TRAP = 8'h3A;
    localparam logic [7:0] O_MRET = 8'h2D;
    localparam logic [7:0] O_BR   = 8'h24;

    pipe_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .timer_int   (timer_int),
        .mstatus_mie (mstatus_mie),
        .mie_mtie    (mie_mtie),
        .valid_de    (valid_de),
        .valid_mw    (valid_mw),
        .br_taken_de (br_taken_de),
        .mret_de     (mret_de),
        .rs1_de      (rs1_de),
        .rs2_de      (rs2_de),
        .rs1_used_de (rs1_used_de),
        .rs2_used_de (rs2_used_de),
        .load_mw     (load_mw),
        .rd_mw       (rd_mw),
        .stall_f     (stall_f),
        .stall_de    (stall_de),
        .flush_f     (flush_f),
        .flush_de    (flush_de),
        .pc_sel      (pc_sel),
        .trap_take   (trap_take),
        .mret_take   (mret_take)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        timer_int = 0; mstatus_mie = 0; mie_mtie = 0;
        valid_de = 0; valid_mw = 0; br_taken_de = 0; mret_de = 0;
        rs1_de = 0; rs2_de = 0; rd_mw = 0;
        rs1_used_de = 0; rs2_used_de = 0; load_mw = 0;
    endtask

    task automatic set_irq();
        timer_int = 1; mie_mtie = 1; mstatus_mie = 1;
    endtask

    task automatic set_load_use(input logic [4:0] r);
        valid_de = 1; valid_mw = 1; load_mw = 1;
        rd_mw = r; rs1_de = r; rs1_used_de = 1;
    endtask

    // Settle combinational outputs, then compare against the expected vector.
    task automatic chk(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        #1;
        obs = {stall_f, stall_de, flush_f, flush_de, pc_sel, trap_take, mret_take};
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        $display("check %-16s observed %02h expected %02h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        #2;
        chk("reset_idle", O_IDLE);
        set_load_use(5'd5);
        set_irq();
        chk("reset_gated", O_IDLE);
        tick();
        clear_inputs();
        rst = 0;

        // first cycle after reset accepts interrupts
        set_irq(); valid_de = 1;
        chk("irq_after_rst", O_TRAP);
        tick();
        chk("trap_blocks", O_IDLE);
        tick();
        clear_inputs();

        // load-use on rs1: one stall, LD_STALL ignores hazard, back to RUN
        set_load_use(5'd5);
        chk("ld_use_rs1", O_HAZ);
        tick();
        chk("ld_stall_free", O_IDLE);
        tick();
        chk("run_again_haz", O_HAZ);
        tick();
        // irq during LD_STALL waits for RUN
        clear_inputs(); set_irq(); valid_de = 1;
        chk("ld_stall_irq", O_IDLE);
        tick();
        chk("irq_after_stall", O_TRAP);
        tick();
        clear_inputs();
        tick();

        // dependent branch resolving in LD_STALL
        set_load_use(5'd9); br_taken_de = 1;
        chk("haz_over_branch", O_HAZ);
        tick();
        chk("ld_stall_branch", O_BR);
        tick();
        clear_inputs();

        // no-hazard cases
        valid_de = 1; valid_mw = 1; load_mw = 1; rd_mw = 0; rs1_de = 0; rs1_used_de = 1;
        chk("rd_x0_no_stall", O_IDLE);
        rd_mw = 5'd3; rs1_de = 5'd3; rs1_used_de = 0;
        chk("rs1_unused", O_IDLE);
        rs1_used_de = 1; valid_mw = 0;
        chk("mw_invalid", O_IDLE);
        valid_mw = 1; load_mw = 0;
        chk("not_load", O_IDLE);
        clear_inputs();
        valid_de = 1; valid_mw = 1; load_mw = 1; rd_mw = 5'd7; rs2_de = 5'd7; rs2_used_de = 1;
        chk("ld_use_rs2", O_HAZ);
        tick();
        clear_inputs();
        tick();

        // branches and interrupt priority
        valid_de = 1; br_taken_de = 1;
        chk("branch", O_BR);
        valid_de = 0;
        chk("branch_invalid", O_IDLE);
        set_irq();
        chk("irq_wait_valid", O_IDLE);
        valid_de = 1; mie_mtie = 0;
        chk("mtie_masked", O_BR);
        mie_mtie = 1;
        chk("irq_over_branch", O_TRAP);
        tick();
        clear_inputs();
        tick();
        set_load_use(5'd4); set_irq();
        chk("haz_over_irq", O_HAZ);
        tick();
        clear_inputs();
        tick();

        // mret with timer pending but MIE clear (inside handler)
        timer_int = 1; mie_mtie = 1; valid_de = 1; mret_de = 1;
        chk("mret_take", O_MRET);
        tick();
        mret_de = 0; mstatus_mie = 1;
        chk("mret_blocks_irq", O_IDLE);
        tick();
        chk("trap_after_mret", O_TRAP);
        tick();
        chk("trap_no_mret", O_IDLE);
        mret_de = 1;
        tick();
        chk("mret_under_irq", O_TRAP);
        tick();
        clear_inputs();
        tick();

        // asynchronous reset mid-TRAP
        set_irq(); valid_de = 1;
        chk("pre_rst_trap", O_TRAP);
        tick();
        #1;
        rst = 1;
        chk("rst_async_out", O_IDLE);
        #1;
        rst = 0;
        chk("rst_state_run", O_TRAP);
        tick();
        clear_inputs();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: timer_int  input  1  level timer interrupt request.
REQ-004 SHALL have ports: mstatus_mie, mie_mtie  input  1 each  global and timer interrupt enables from the CSR file.
REQ-005 SHALL have ports: valid_de, valid_mw  input  1 each  stage holds a live instruction.
REQ-006 SHALL have ports: br_taken_de, mret_de  input  1 each  taken branch/jump or mret resolved in DE.
REQ-007 SHALL have ports: rs1_de, rs2_de  input  5 each; rs1_used_de, rs2_used_de  input  1 each  DE source operands.
REQ-008 SHALL have ports: load_mw  input  1; rd_mw  input  5  load occupying MW and its destination.
REQ-009 SHALL have ports: stall_f, stall_de  output  1 each  hold PC and IF/DE register.
REQ-010 SHALL have ports: flush_f, flush_de  output  1 each  squash IF/DE register; insert bubble into DE/MW.
REQ-011 SHALL have port: pc_sel  output  2  next-PC source: 0 PC+4, 1 branch target, 2 mtvec, 3 mepc.
REQ-012 SHALL have ports: trap_take, mret_take  output  1 each  one-cycle pulses to CSR file (save mepc/mcause, clear MIE; restore MIE).

Function
REQ-013 SHALL implement FSM states RUN, LD_STALL, TRAP, MRET.
REQ-014 irq_pend SHALL equal timer_int & mie_mtie & mstatus_mie, sampled combinationally each cycle.
REQ-015 Load-use hazard SHALL be valid_de & valid_mw & load_mw & rd_mw!=0 & ((rs1_used_de & rs1_de==rd_mw) | (rs2_used_de & rs2_de==rd_mw)).
REQ-016 In RUN with hazard: stall_f=stall_de=1, flush_de=1, pc_sel=0, next state LD_STALL; exactly one stall cycle.
REQ-017 LD_STALL SHALL drive no stall and return to RUN next cycle; DE instruction proceeds with forwarded data.
REQ-018 In RUN, irq_pend & valid_de & no hazard: trap_take=1, flush_f=1, flush_de=1, pc_sel=2, next TRAP; DE instruction is not executed (its PC becomes mepc).
REQ-019 TRAP SHALL last one cycle, block interrupt and mret acceptance, drive pc_sel=0, return to RUN.
REQ-020 In RUN, mret_de & valid_de & no irq: mret_take=1, flush_f=1, pc_sel=3, next MRET.
REQ-021 MRET SHALL last one cycle with interrupts blocked, guaranteeing one instruction at mepc enters DE before any new trap.
REQ-022 In RUN, br_taken_de & valid_de & no irq & no hazard: flush_f=1, pc_sel=1, state stays RUN.
REQ-023 Priority SHALL be hazard > interrupt > mret > branch; a pending interrupt during LD_STALL SHALL be taken in the following RUN cycle.
REQ-024 Interrupt coincident with taken branch SHALL take the trap; branch re-executes after return.
REQ-025 Inputs qualified by valid_*=0 SHALL be ignored; irq with valid_de=0 SHALL wait.
REQ-026 Outputs SHALL be combinational from state and inputs (Mealy); trap_take and mret_take SHALL never assert together or for two consecutive cycles.

Reset
REQ-027 On rst assertion state SHALL become RUN immediately, independent of clk.
REQ-028 During reset all outputs SHALL be 0 (pc_sel=0); a trap or stall in progress SHALL be abandoned without pulse.
REQ-029 First cycle after reset release SHALL accept interrupts.

Structure
REQ-030 Package pipe_ctrl_pkg SHALL hold the state enum and pc_sel encodings (PC_PLUS4, PC_BR, PC_MTVEC, PC_MEPC).
REQ-031 Load-use detection SHALL be a combinational sub-module hazard_unit instantiated once.

Verification
REQ-032 load_mw=1, rd_mw=5, rs1_de=5, rs1_used_de=1 -> stall_f=stall_de=flush_de=1 one cycle, then LD_STALL, then RUN.
REQ-033 rd_mw=0 with rs1_de=0 load -> no stall.
REQ-034 timer_int=mie_mtie=mstatus_mie=1, valid_de=1 -> trap_take=1, pc_sel=2, flush_f=flush_de=1 that cycle; next cycle trap_take=0, irq ignored.
REQ-035 br_taken_de=1 and irq_pend=1 same cycle -> pc_sel=2, trap_take=1, no pc_sel=1.
REQ-036 mret_de=1 with timer_int held high -> mret_take=1, pc_sel=3; next cycle no trap; trap_take=1 the cycle after.
REQ-037 rst asserted mid-TRAP between clock edges -> outputs 0 immediately; state RUN after release.
